// File: rtl/control_sequencer.sv
// control_sequencer: two-state FETCH/EXEC controller for a simple 8-bit CPU.
// Holds the program counter and the latched instruction register (IR), and
// decodes IR into ALU, operand-select, register-address and write-strobe
// controls during EXEC.
//
// Ports:
//   CLK          system clock, all state changes on rising edge
//   RESET        synchronous active-high reset
//   INSTRUCTION  instruction word from instruction memory
//                (OP[31:24], DEST/OFFSET[23:16], SRC1[15:8], SRC2/IMM[7:0])
//   IBUSYWAIT    instruction memory not ready; stalls FETCH
//   ZERO         ALU zero flag, consulted by beq at the end of EXEC
//   PC           address of the instruction being fetched or executed
//   ALUOP        ALU select (000 forward, 001 add, 010 and, 011 or)
//   WRITEENABLE  register-file write strobe
//   IMM_SEL      operand 2 is IMMEDIATE when 1, register SRC2 when 0
//   NEG_SEL      operand 2 is two's-complemented when 1
//   WRITEREG     DEST[2:0] of IR
//   READREG1     SRC1[2:0] of IR
//   READREG2     SRC2[2:0] of IR
//   IMMEDIATE    IMM field of IR
module control_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        IBUSYWAIT,
  input  logic        ZERO,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic        WRITEENABLE,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  WRITEREG,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [7:0]  IMMEDIATE
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPW   = 8;
  localparam int unsigned ALUW  = 3;
  localparam int unsigned REGW  = 3;
  localparam int unsigned OFFW  = 8;

  localparam logic [OPW-1:0] OP_LOADI = 8'h00;
  localparam logic [OPW-1:0] OP_MOV   = 8'h01;
  localparam logic [OPW-1:0] OP_ADD   = 8'h02;
  localparam logic [OPW-1:0] OP_SUB   = 8'h03;
  localparam logic [OPW-1:0] OP_AND   = 8'h04;
  localparam logic [OPW-1:0] OP_OR    = 8'h05;
  localparam logic [OPW-1:0] OP_J     = 8'h06;
  localparam logic [OPW-1:0] OP_BEQ   = 8'h07;

  localparam logic [ALUW-1:0] ALU_FWD = 3'b000;
  localparam logic [ALUW-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUW-1:0] ALU_AND = 3'b010;
  localparam logic [ALUW-1:0] ALU_OR  = 3'b011;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;

  // IR field views
  logic [OPW-1:0]  ir_op;
  logic [OFFW-1:0] ir_off;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic            take_target;
  logic            we_raw;

  // SRC1/SRC2 upper bits are not decoded by this controller
  logic unused_ir_bits;

  assign ir_op          = ir_q[31:24];
  assign ir_off         = ir_q[23:16];
  assign unused_ir_bits = ^{ir_q[15:11], ir_q[7:3]};

  // Branch/jump target: PC + 4 + (sext(OFFSET) << 2), wrapping mod 2^32
  assign pc_plus4  = pc_q + PC_STEP;
  assign pc_target = pc_plus4 + {{(XLEN-OFFW-2){ir_off[OFFW-1]}}, ir_off, 2'b00};

  assign take_target = (ir_op == OP_J) || ((ir_op == OP_BEQ) && ZERO);

  // State register: reset wins over any pending fetch or EXEC update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, IR capture and PC update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (!IBUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d    = take_target ? pc_target : pc_plus4;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Output decode from IR; everything idle outside EXEC
  always_comb begin
    ALUOP   = ALU_FWD;
    IMM_SEL = 1'b0;
    NEG_SEL = 1'b0;
    we_raw  = 1'b0;
    if (state_q == ST_EXEC) begin
      unique case (ir_op)
        OP_LOADI: begin
          ALUOP   = ALU_FWD;
          IMM_SEL = 1'b1;
          we_raw  = 1'b1;
        end
        OP_MOV: begin
          ALUOP  = ALU_FWD;
          we_raw = 1'b1;
        end
        OP_ADD: begin
          ALUOP  = ALU_ADD;
          we_raw = 1'b1;
        end
        OP_SUB: begin
          ALUOP   = ALU_ADD;
          NEG_SEL = 1'b1;
          we_raw  = 1'b1;
        end
        OP_AND: begin
          ALUOP  = ALU_AND;
          we_raw = 1'b1;
        end
        OP_OR: begin
          ALUOP  = ALU_OR;
          we_raw = 1'b1;
        end
        OP_J: begin
          ALUOP = ALU_FWD;
        end
        OP_BEQ: begin
          ALUOP   = ALU_ADD;
          NEG_SEL = 1'b1;
        end
        default: begin
          ALUOP = ALU_FWD;
        end
      endcase
    end
  end

  // Write strobe is killed combinationally by RESET so an interrupted EXEC never writes
  assign WRITEENABLE = we_raw & ~RESET;

  assign PC        = pc_q;
  assign WRITEREG  = ir_q[16 +: REGW];
  assign READREG1  = ir_q[8 +: REGW];
  assign READREG2  = ir_q[0 +: REGW];
  assign IMMEDIATE = ir_q[7:0];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer. Each table row gives the
// inputs for one clock cycle and the outputs expected during that cycle.
module tb_control_sequencer;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        IBUSYWAIT;
  logic        ZERO;
  logic [31:0] PC;
  logic [2:0]  ALUOP;
  logic        WRITEENABLE;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [2:0]  WRITEREG;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [7:0]  IMMEDIATE;

  control_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .IBUSYWAIT   (IBUSYWAIT),
    .ZERO        (ZERO),
    .PC          (PC),
    .ALUOP       (ALUOP),
    .WRITEENABLE (WRITEENABLE),
    .IMM_SEL     (IMM_SEL),
    .NEG_SEL     (NEG_SEL),
    .WRITEREG    (WRITEREG),
    .READREG1    (READREG1),
    .READREG2    (READREG2),
    .IMMEDIATE   (IMMEDIATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        busy;
    logic [31:0] instr;
    logic        zero;
    logic [31:0] e_pc;
    logic [2:0]  e_alu;
    logic        e_we;
    logic        e_isel;
    logic        e_neg;
    logic [2:0]  e_wr;
    logic [2:0]  e_r1;
    logic [2:0]  e_r2;
    logic [7:0]  e_imm;
  } vec_t;

  localparam int NVEC = 34;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(logic rst, logic busy, logic [31:0] instr, logic zero,
                              logic [31:0] pc, logic [2:0] alu, logic we, logic isel,
                              logic neg, logic [2:0] wr, logic [2:0] r1, logic [2:0] r2,
                              logic [7:0] imm);
    vec_t v;
    v.rst = rst; v.busy = busy; v.instr = instr; v.zero = zero;
    v.e_pc = pc; v.e_alu = alu; v.e_we = we; v.e_isel = isel; v.e_neg = neg;
    v.e_wr = wr; v.e_r1 = r1; v.e_r2 = r2; v.e_imm = imm;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic busy, input logic [31:0] instr,
                       input logic zero);
    RESET       = rst;
    IBUSYWAIT   = busy;
    INSTRUCTION = instr;
    ZERO        = zero;
  endtask

  initial begin
    //         rst busy instr         z   pc            alu we is ng wr r1 r2 imm
    vecs[0]  = mk(1, 0, 32'h00040007, 0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(0, 0, 32'h00040007, 0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    // loadi r4,7 in EXEC; live INSTRUCTION is garbage to prove decode uses IR
    vecs[2]  = mk(0, 0, 32'hFFFFFFFF, 0, 32'h00000000, 0, 1, 1, 0, 4, 0, 7, 8'h07);
    vecs[3]  = mk(0, 0, 32'h3F000000, 0, 32'h00000004, 0, 0, 0, 0, 4, 0, 7, 8'h07);
    vecs[4]  = mk(0, 1, 32'h00000000, 0, 32'h00000004, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    // three stall cycles at PC 8, then latch sub
    vecs[5]  = mk(0, 1, 32'h03020103, 0, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[6]  = mk(0, 1, 32'h03020103, 0, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[7]  = mk(0, 1, 32'h03020103, 0, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[8]  = mk(0, 0, 32'h03020103, 0, 32'h00000008, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[9]  = mk(0, 0, 32'h00000000, 0, 32'h00000008, 1, 1, 0, 1, 2, 1, 3, 8'h03);
    vecs[10] = mk(0, 0, 32'h02050607, 0, 32'h0000000C, 0, 0, 0, 0, 2, 1, 3, 8'h03);
    // RESET during EXEC of add: write suppressed, PC and IR cleared
    vecs[11] = mk(1, 0, 32'h00000000, 0, 32'h0000000C, 1, 0, 0, 0, 5, 6, 7, 8'h07);
    vecs[12] = mk(0, 0, 32'h06030000, 0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[13] = mk(0, 0, 32'h00000000, 0, 32'h00000000, 0, 0, 0, 0, 3, 0, 0, 8'h00);
    // beq -2 at 0x10, ZERO=1 -> 0x0C
    vecs[14] = mk(0, 0, 32'h07FE0102, 0, 32'h00000010, 0, 0, 0, 0, 3, 0, 0, 8'h00);
    vecs[15] = mk(0, 0, 32'h00000000, 1, 32'h00000010, 1, 0, 0, 1, 6, 1, 2, 8'h02);
    vecs[16] = mk(0, 0, 32'h06000000, 0, 32'h0000000C, 0, 0, 0, 0, 6, 1, 2, 8'h02);
    vecs[17] = mk(0, 0, 32'h00000000, 0, 32'h0000000C, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    // beq -2 at 0x10, ZERO=0 -> 0x14
    vecs[18] = mk(0, 0, 32'h07FE0102, 1, 32'h00000010, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[19] = mk(0, 0, 32'h00000000, 0, 32'h00000010, 1, 0, 0, 1, 6, 1, 2, 8'h02);
    // j -8 from 0x14 wraps below zero to 0xFFFFFFF8
    vecs[20] = mk(0, 0, 32'h06F80000, 0, 32'h00000014, 0, 0, 0, 0, 6, 1, 2, 8'h02);
    vecs[21] = mk(0, 0, 32'h00000000, 0, 32'h00000014, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    // j +2 from 0xFFFFFFF8 wraps past 2^32 to 0x4
    vecs[22] = mk(0, 0, 32'h06020000, 1, 32'hFFFFFFF8, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    vecs[23] = mk(0, 0, 32'h00000000, 0, 32'hFFFFFFF8, 0, 0, 0, 0, 2, 0, 0, 8'h00);
    vecs[24] = mk(0, 0, 32'h06FD0000, 0, 32'h00000004, 0, 0, 0, 0, 2, 0, 0, 8'h00);
    vecs[25] = mk(0, 0, 32'h00000000, 0, 32'h00000004, 0, 0, 0, 0, 5, 0, 0, 8'h00);
    // and at 0xFFFFFFFC: PC+4 wraps to 0
    vecs[26] = mk(0, 0, 32'h04010203, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 5, 0, 0, 8'h00);
    vecs[27] = mk(0, 0, 32'h00000000, 0, 32'hFFFFFFFC, 2, 1, 0, 0, 1, 2, 3, 8'h03);
    vecs[28] = mk(0, 0, 32'h05070605, 0, 32'h00000000, 0, 0, 0, 0, 1, 2, 3, 8'h03);
    vecs[29] = mk(0, 0, 32'h00000000, 0, 32'h00000000, 3, 1, 0, 0, 7, 6, 5, 8'h05);
    vecs[30] = mk(0, 0, 32'h01030400, 0, 32'h00000004, 0, 0, 0, 0, 7, 6, 5, 8'h05);
    vecs[31] = mk(0, 0, 32'h00000000, 0, 32'h00000004, 0, 1, 0, 0, 3, 4, 0, 8'h00);
    // RESET in FETCH beats a ready instruction
    vecs[32] = mk(1, 0, 32'h07000000, 0, 32'h00000008, 0, 0, 0, 0, 3, 4, 0, 8'h00);
    vecs[33] = mk(0, 1, 32'h00000000, 0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 8'h00);

    drive(1, 0, 32'h0, 0);
    repeat (2) @(posedge CLK);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].busy, vecs[i].instr, vecs[i].zero);
      #1;
      chk("PC",          i, PC,                  vecs[i].e_pc);
      chk("ALUOP",       i, 32'(ALUOP),          32'(vecs[i].e_alu));
      chk("WRITEENABLE", i, 32'(WRITEENABLE),    32'(vecs[i].e_we));
      chk("IMM_SEL",     i, 32'(IMM_SEL),        32'(vecs[i].e_isel));
      chk("NEG_SEL",     i, 32'(NEG_SEL),        32'(vecs[i].e_neg));
      chk("WRITEREG",    i, 32'(WRITEREG),       32'(vecs[i].e_wr));
      chk("READREG1",    i, 32'(READREG1),       32'(vecs[i].e_r1));
      chk("READREG2",    i, 32'(READREG2),       32'(vecs[i].e_r2));
      chk("IMMEDIATE",   i, 32'(IMMEDIATE),      32'(vecs[i].e_imm));
    end

    // Long IBUSYWAIT stall at PC 0: PC holds, no write, no premature EXEC
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      drive(0, 1, 32'h00010055, 0);
      #1;
      chk("stall_PC", 100 + c, PC, 32'h00000000);
      chk("stall_WE", 100 + c, 32'(WRITEENABLE), 32'h0);
      chk("stall_IMM_SEL", 100 + c, 32'(IMM_SEL), 32'h0);
    end
    @(negedge CLK);
    drive(0, 0, 32'h00010055, 0);
    #1;
    chk("release_WE", 200, 32'(WRITEENABLE), 32'h0);
    @(negedge CLK);
    drive(0, 1, 32'hDEADBEEF, 0);
    #1;
    chk("exec_WE",        201, 32'(WRITEENABLE), 32'h1);
    chk("exec_IMM_SEL",   201, 32'(IMM_SEL),     32'h1);
    chk("exec_WRITEREG",  201, 32'(WRITEREG),    32'h1);
    chk("exec_IMMEDIATE", 201, 32'(IMMEDIATE),   32'h55);
    chk("exec_PC",        201, PC,               32'h00000000);
    @(negedge CLK);
    #1;
    chk("post_PC", 202, PC,               32'h00000004);
    chk("post_WE", 202, 32'(WRITEENABLE), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
